// File: rtl/alu_mc.sv
// Multi-cycle RV32 ALU: single-cycle base ops registered at latency 1, plus the M
// extension on an iterative radix-2 shift-add multiplier / restoring divider.
module alu_mc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic [2*XLEN-1:0] acc, mcand, acc_n, mcand_n, prod;
    logic [XLEN-1:0]   mplier, mplier_n, quo_v, rem_v, fin_res;
    logic [SHAMT_W-1:0] cnt;
    logic              q_neg, r_neg, sel_hi, div_q, rem_q;

    logic [XLEN-1:0]   base_res, spec_res, a_mag, b_mag;
    logic              base_ill, base_zero, a_sgn, b_sgn, a_neg, b_neg;
    logic              dbz, ovf, m_special, accept;
    logic [2:0]        f3;
    logic [XLEN:0]     r_sh, diff;
    logic [SHAMT_W-1:0] shamt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready & ~flush;
    assign shamt     = b[SHAMT_W-1:0];

    always_comb begin
        base_res = '0;
        base_ill = 1'b0;
        case (op[3:0])
            4'b0000: base_res = a & b;
            4'b0001: base_res = a | b;
            4'b0010: base_res = a + b;
            4'b0110: base_res = a - b;
            4'b0011: base_res = a ^ b;
            4'b0100: base_res = a << shamt;
            4'b0101: base_res = a >> shamt;
            4'b1001: base_res = $signed(a) >>> shamt;
            4'b0111: base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1000: base_res = {{(XLEN-1){1'b0}}, a < b};
            default: base_ill = 1'b1;
        endcase
    end
    assign base_zero = (op[3:0] == 4'b0110) && (a == b);

    // Operand signedness by funct3; MUL low half is sign-agnostic so treat it as s x s.
    assign f3    = op[2:0];
    assign a_sgn = f3[2] ? ~f3[0] : (f3 != 3'b011);
    assign b_sgn = f3[2] ? ~f3[0] : ~f3[1];
    assign a_neg = a_sgn & a[XLEN-1];
    assign b_neg = b_sgn & b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign dbz       = (b == '0);
    assign ovf       = ~f3[0] & (a == MIN_NEG) & (b == '1);
    assign m_special = f3[2] & (dbz | ovf);
    assign spec_res  = f3[1] ? (dbz ? a : '0) : (dbz ? '1 : a);

    always_comb begin
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        r_sh     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff     = r_sh - {1'b0, mplier};
        if (div_q) begin
            // acc = {partial remainder, dividend shifting out / quotient shifting in}
            if (!diff[XLEN]) acc_n = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else             acc_n = {r_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            if (mplier[0]) acc_n = acc + mcand;
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
        end
    end

    always_comb begin
        prod    = q_neg ? -acc_n : acc_n;
        rem_v   = r_neg ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
        quo_v   = q_neg ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
        fin_res = prod[XLEN-1:0];
        if (div_q)       fin_res = rem_q ? rem_v : quo_v;
        else if (sel_hi) fin_res = prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (op[4] && !m_special) ? BUSY : DONE;
            BUSY:    if (cnt == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            sel_hi  <= 1'b0;
            div_q   <= 1'b0;
            rem_q   <= 1'b0;
        end else if (accept) begin
            cnt     <= SHAMT_W'(XLEN - 1);
            zero    <= 1'b0;
            illegal <= 1'b0;
            if (!op[4]) begin
                result  <= base_res;
                zero    <= base_zero;
                illegal <= base_ill;
            end else if (m_special) begin
                result <= spec_res;
            end else begin
                div_q  <= f3[2];
                rem_q  <= f3[1];
                sel_hi <= (f3[1:0] != 2'b00);
                q_neg  <= a_neg ^ b_neg;
                r_neg  <= a_neg;
                mplier <= b_mag;
                mcand  <= {{XLEN{1'b0}}, a_mag};
                acc    <= f3[2] ? {{XLEN{1'b0}}, a_mag} : '0;
            end
        end else if (state == BUSY) begin
            acc    <= acc_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            cnt    <= cnt - 1'b1;
            if (cnt == '0) result <= fin_res;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed + randomized checks of alu_mc against a plain-arithmetic reference model.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        in_ready, out_valid, zero, illegal;
    logic [31:0] result;

    logic        in_valid16 = 1'b0;
    logic [4:0]  op16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        in_ready16, out_valid16, zero16, illegal16;
    logic [15:0] result16;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_mc #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal));

    alu_mc #(.XLEN(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
        .a(a16), .b(b16), .flush(1'b0), .out_valid(out_valid16), .out_ready(1'b1),
        .result(result16), .zero(zero16), .illegal(illegal16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic bit is_special(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        return o[4] && o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    function automatic bit model_ill(input logic [4:0] o);
        if (o[4]) return 1'b0;
        return !(o[3:0] inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9});
    endfunction

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        int qi;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        if (!o[4]) begin
            case (o[3:0])
                4'd0: return x & y;
                4'd1: return x | y;
                4'd2: return 32'(ux + uy);
                4'd6: return 32'(ux - uy);
                4'd3: return x ^ y;
                4'd4: return 32'(ux * (64'd1 << y[4:0]));
                4'd5: return 32'(ux / (64'd1 << y[4:0]));
                4'd9: begin
                    qi = int'(sx >>> y[4:0]);
                    return 32'(qi);
                end
                4'd7: return (sx < sy) ? 32'd1 : 32'd0;
                4'd8: return (ux < uy) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        end
        case (o[2:0])
            3'd0: begin p = 64'(sx * sy); return p[31:0]; end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = 64'(ux) * 64'(uy); return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return 32'(sx / sy);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : 32'(ux / uy);
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sx % sy);
            end
            default: return (y == 0) ? x : 32'(ux % uy);
        endcase
    endfunction

    // Issue one op, check latency/busy behaviour and the result, then complete the handshake.
    task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        int lat;
        int exp_lat;
        exp_lat = (o[4] && !is_special(o, x, y)) ? 33 : 1;
        @(negedge clk);
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        if (!out_valid) chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency op=%h", o), lat, exp_lat);
        chk($sformatf("result op=%h a=%h b=%h", o, x, y), result, model(o, x, y));
        chk("zero", {31'b0, zero}, {31'b0, (o == 5'b00110) && (x == y)});
        chk("illegal", {31'b0, illegal}, {31'b0, model_ill(o)});
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk("out_valid_after_hs", {31'b0, out_valid}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int seen;
        logic [31:0] hold;
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {30'b0, zero, illegal}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        do_op(5'b00010, 32'd5, 32'd7);
        do_op(5'b00110, 32'h1234, 32'h1234);
        do_op(5'b01001, 32'h8000_0000, 32'h24);
        do_op(5'b00111, 32'hFFFF_FFFF, 32'd1);
        do_op(5'b01000, 32'hFFFF_FFFF, 32'd1);
        do_op(5'b01010, 32'd3, 32'd4);
        do_op(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(5'b10100, -32'sd7, 32'd2);
        do_op(5'b10110, -32'sd7, 32'd2);
        do_op(5'b10101, 32'd7, 32'd0);
        do_op(5'b11110, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(5'b10010, 32'hFFFF_FFFE, 32'h8000_0001);

        // Backpressure: result held, new request ignored while DONE.
        @(negedge clk); in_valid = 1'b1; op = 5'b10101; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1; in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("bp_result", result, 32'd142);
        hold = result;
        @(negedge clk); in_valid = 1'b1; op = 5'b00010; a = 32'd1; b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_stable", result, hold);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk("bp_released", {30'b0, out_valid, in_ready}, 32'd1);

        // Flush at BUSY cycle 10, then flush racing a request in IDLE.
        @(negedge clk); in_valid = 1'b1; op = 5'b10000; a = 32'd9; b = 32'd9;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_idle", {30'b0, out_valid, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        chk("flush_no_result", seen, 0);
        @(negedge clk); flush = 1'b1; in_valid = 1'b1; op = 5'b00010;
        @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
        chk("flush_beats_accept", {30'b0, out_valid, in_ready}, 32'd1);

        // Asynchronous reset mid-BUSY.
        @(negedge clk); in_valid = 1'b1; op = 5'b10100; a = 32'd100; b = 32'd3;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_outs", {result[29:0], out_valid, zero}, 32'd0);
        chk("arst_illegal", {31'b0, illegal}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        do_op(5'b10111, 32'd100, 32'd7);

        // XLEN=16 instance: MULHU at latency XLEN+1.
        @(negedge clk); in_valid16 = 1'b1; op16 = 5'b10011; a16 = 16'hFFFF; b16 = 16'hFFFF;
        @(posedge clk); #1; in_valid16 = 1'b0;
        lat = 1;
        while (!out_valid16 && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("x16_latency", lat, 17);
        chk("x16_mulhu", {16'b0, result16}, 32'h0000_FFFE);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] ro;
            ro = ($urandom_range(0, 1) == 1) ? {2'b1, 3'($urandom)} | 5'({$urandom_range(0, 1), 3'b0})
                                              : {1'b0, 4'($urandom)};
            do_op(ro, pick(), pick());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle integer ALU in the RV32 datapath.
- Executes the existing base operations with a registered 1-cycle latency.
- Adds the RISC-V M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) using an iterative radix-2 engine.
- Sits between decode/issue and writeback behind a valid/ready handshake, so the core stalls on long ops.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, at least 8.
- SHAMT_W, $clog2(XLEN), derived localparam, shift-amount width; not overridable.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operation request.
- in_ready, output, 1, unit can accept a request.
- op, input, 5, operation select. op[4]=0 selects base ops (op[3:0] uses the existing ALU Control_in codes). op[4]=1 selects M ops (op[2:0]=funct3), with op[3] ignored.
- a, input, XLEN, operand A (rs1).
- b, input, XLEN, operand B (rs2).
- flush, input, 1, synchronous abort of any operation in flight.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts result.
- result, output, XLEN, operation result.
- zero, output, 1, A==B flag (SUB only).
- illegal, output, 1, op code was unsupported.

Behaviour:
- Reset (rst_n low, async): state=IDLE; in_ready=1; out_valid=0; result=0; zero=0; illegal=0; counter and internal registers cleared.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). There is no overlap: a new request is accepted only after the previous result has been taken.
- Accept = in_valid & in_ready. Operands and op are captured at the accept edge and need not be held afterwards.
- Base op accepted goes IDLE->DONE. result/zero/illegal are registered, and out_valid=1 on the next cycle (latency 1).
  - Base op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0100 SLL, 0101 SRL, 1001 SRA, 0111 SLT, 1000 SLTU.
  - Shifts use b[SHAMT_W-1:0]. SLT/SLTU return 1 or 0, zero-extended.
  - zero=1 only for SUB with a==b; zero=0 for every other op.
  - Any other base code: result=0, zero=0, illegal=1, still completes in 1 cycle.
- MUL-class op goes IDLE->BUSY. Shift-add runs over a 2*XLEN product on operand magnitudes with sign correction per variant.
  - MUL returns the low XLEN bits.
  - MULH (s×s), MULHSU (s×u) and MULHU (u×u) return the high XLEN bits.
- DIV-class op goes IDLE->BUSY. Restoring division on magnitudes, with quotient sign = sa^sb and remainder sign = sa.
- BUSY lasts exactly XLEN cycles (counter loaded with XLEN-1 at accept, decrements to 0), then DONE. out_valid rises XLEN+1 cycles after the accept edge.
- Special cases skip BUSY and go IDLE->DONE (latency 1):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = a.
  - Signed overflow (a = most negative, b = -1): DIV = a; REM = 0.
- DONE: out_valid=1. result/zero/illegal are held stable until out_ready=1, then DONE->IDLE.
  - A new request can be accepted only in the cycle after the handshake; there is no same-cycle back-to-back.
- out_valid, when high, never drops without out_ready, except on flush or reset.
- flush=1 from any state: next state IDLE, out_valid=0, result discarded.
  - If flush and in_valid are both high in IDLE, flush wins and nothing is accepted.
- rst_n asserted mid-BUSY aborts immediately to reset values; no result is produced.
- op[4]=1 never sets zero. illegal=0 for all 8 M ops.

Test Plan:
- Reset, then ADD a=5 b=7 -> result=12, zero=0, out_valid exactly 1 cycle after accept; SUB a=b=0x1234 -> result=0, zero=1.
- SRA a=0x80000000 b=0x24 (shamt=4) -> 0xF8000000; SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0; op=0x0A -> result=0, illegal=1.
- MULH a=0xFFFFFFFF b=0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MUL same operands -> 1; out_valid exactly 33 cycles after accept, in_ready=0 throughout.
- DIV a=-7 b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=7 b=0 -> 0xFFFFFFFF in 1 cycle; REM a=0x80000000 b=0xFFFFFFFF -> 0 in 1 cycle.
- Backpressure: out_ready=0 for 5 cycles after a DIVU -> result stable and out_valid held; in_valid asserted meanwhile is not accepted.
- flush at BUSY cycle 10 -> IDLE next cycle, out_valid stays 0; rst_n low mid-BUSY -> all outputs 0 and in_ready=1 asynchronously; with XLEN=16, MULHU 0xFFFF×0xFFFF -> 0xFFFE at latency 17.
